// File: rtl/libhdl_jkdrvn.sv
// Command-driven excitation generator for an external N-bit JK register.
// Each command drives J/K for one cycle, then checks the fed-back Q against the expected value.
module libhdl_jkdrvn #(
  parameter int unsigned N = 1
) (
  input  logic         ck,
  input  logic         rn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_data,
  input  logic [N-1:0] q_fb,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic         done,
  output logic         mismatch,
  output logic         err,
  input  logic         err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  state_t       state, state_nx;
  logic [N-1:0] e, e_nx;
  logic [N-1:0] j_nx, k_nx;
  logic         done_nx, mismatch_nx, err_nx;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx    = state;
    e_nx        = e;
    j_nx        = '0;
    k_nx        = '0;
    done_nx     = 1'b0;
    mismatch_nx = 1'b0;
    err_nx      = err_clr ? 1'b0 : err;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = DRIVE;
          unique case (op_t'(cmd_op))
            OP_LOAD: begin
              // Bits already equal to the target get J=K=0 and simply hold.
              j_nx = cmd_data & ~q_fb;
              k_nx = ~cmd_data & q_fb;
              e_nx = cmd_data;
            end
            OP_CLEAR: begin
              k_nx = '1;
              e_nx = '0;
            end
            OP_SET: begin
              j_nx = '1;
              e_nx = '1;
            end
            OP_TOGGLE: begin
              j_nx = cmd_data;
              k_nx = cmd_data;
              e_nx = q_fb ^ cmd_data;
            end
            default: ;
          endcase
        end
      end
      DRIVE: state_nx = CHECK;
      CHECK: begin
        state_nx    = IDLE;
        done_nx     = 1'b1;
        mismatch_nx = (q_fb != e);
        // A mismatch on the same edge as err_clr keeps the error flag set.
        if (q_fb != e) err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nx;
    end
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      e        <= '0;
      j        <= '0;
      k        <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      err      <= 1'b0;
    end else begin
      e        <= e_nx;
      j        <= j_nx;
      k        <= k_nx;
      done     <= done_nx;
      mismatch <= mismatch_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: doc/libhdl_jkdrvn.md
LIBHDL_JKDRVN -- requirements
Module: libhdl_jkdrvN

Parameters
REQ-001 The block SHALL have parameter N, default 1, giving the width of the driven JK register (N >= 1).

Interface
REQ-002 The block SHALL have port CK, input, width 1: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port RN, input, width 1: the asynchronous, active-low reset.
REQ-004 The block SHALL have port CMD_VALID, input, width 1: command present.
REQ-005 The block SHALL have port CMD_READY, output, width 1: block can accept a command.
REQ-006 The block SHALL have port CMD_OP, input, width 2: 00 LOAD, 01 CLEAR, 10 SET, 11 TOGGLE.
REQ-007 The block SHALL have port CMD_DATA, input, width N: LOAD target value, or TOGGLE bit mask; ignored for CLEAR and SET.
REQ-008 The block SHALL have port Q_FB, input, width N: Q fed back from the driven JK register.
REQ-009 The block SHALL have ports J and K, outputs, width N each, registered: excitation to the JK register.
REQ-010 The block SHALL have port DONE, output, width 1, registered: one-cycle completion pulse.
REQ-011 The block SHALL have port MISMATCH, output, width 1, registered: qualifies DONE; Q_FB differed from the expected value.
REQ-012 The block SHALL have port ERR, output, width 1: sticky error, set by any mismatch.
REQ-013 The block SHALL have port ERR_CLR, input, width 1: synchronous clear of ERR.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE and CHECK; CMD_READY SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted at a rising edge where CMD_VALID=1 and CMD_READY=1.
REQ-016 On acceptance the block SHALL sample Q_FB as q0, register J/K per REQ-017, compute the expected value E, and enter DRIVE.
REQ-017 Excitation SHALL be:
- LOAD: J = D & ~q0, K = ~D & q0, so that equal bits hold.
- CLEAR: J = 0, K = all-ones.
- SET: J = all-ones, K = 0.
- TOGGLE: J = K = D.
REQ-018 The expected value E SHALL be:
- LOAD: D.
- CLEAR: 0.
- SET: all-ones.
- TOGGLE: q0 ^ D.
REQ-019 J/K SHALL be non-zero for exactly one cycle (DRIVE). On the DRIVE->CHECK edge J and K SHALL return to 0 (hold).
REQ-020 In CHECK, at the next edge the block SHALL compare Q_FB with E, pulse DONE=1 for one cycle, set MISMATCH = (Q_FB != E), and return to IDLE.
REQ-021 MISMATCH SHALL be 0 whenever DONE=0.
REQ-022 Latency SHALL be 3 edges from acceptance to DONE visible. DONE and CMD_READY are both 1 in the same cycle, so a back-to-back command SHALL be accepted in the DONE cycle, giving a throughput of one command per 3 cycles.
REQ-023 CMD_VALID, CMD_OP and CMD_DATA SHALL be ignored outside IDLE, and no command SHALL be queued.
REQ-024 Q_FB SHALL be ignored except at acceptance and at the CHECK edge.
REQ-025 ERR SHALL set on the edge MISMATCH is produced as 1.
- ERR_CLR=1 SHALL clear ERR on the next edge.
- A simultaneous mismatch SHALL win: ERR stays 1.
REQ-026 Any CMD_OP value SHALL be legal. LOAD with D == q0 SHALL drive J = K = 0 and still complete with DONE.

Reset
REQ-027 RN=0 SHALL asynchronously force state=IDLE, J=0, K=0, DONE=0, MISMATCH=0, ERR=0, and internal q0/E to 0.
REQ-028 CMD_READY SHALL be 1 during and immediately after reset.
REQ-029 Reset asserted in DRIVE or CHECK SHALL abort the command, with no DONE ever produced for it.
REQ-030 Reset release SHALL take effect at the first CK edge with RN=1.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- N=4, ideal JK model, Q=0101, LOAD D=0011 -> DRIVE cycle J=0010, K=0100; J/K=0 next cycle; DONE=1, MISMATCH=0 at edge 3; Q=0011.
- Q=0011, TOGGLE D=1001 -> J=K=1001; E=1010; DONE with MISMATCH=0.
- CLEAR then SET back-to-back (second CMD_VALID held during DONE cycle) -> second accepted in DONE cycle; J/K=0000/1111 then 1111/0000; two DONE pulses 3 cycles apart; Q=1111.
- Q_FB stuck at 0000, SET -> DONE=1, MISMATCH=1, ERR=1 and stays 1; ERR_CLR pulse -> ERR=0 next edge; ERR_CLR with a simultaneous mismatch -> ERR stays 1.
- RN low during DRIVE -> J=K=0 immediately (asynchronous), no DONE; after release CMD_READY=1 and a LOAD completes normally.
- CMD_VALID held in DRIVE/CHECK with changing CMD_DATA -> ignored; only the IDLE-sampled command executes.
